// File: rtl/mux_2to1.sv
// mux_2to1: registered, flow-controlled 2:1 stream selector (a/b -> s, chosen by sel).
// Latency 1 clock from input handshake to s/s_valid; throughput 1 word/cycle with s_ready high.
// Backpressure: the output register loads when empty or being drained; only the selected input sees ready.
// Ports: clk, rst (async active-high); a/a_valid/a_ready and b/b_valid/b_ready inputs; sel (0=A, 1=B);
//        s/s_valid/s_ready output; sw_count (8-bit) only when MUX_2TO1_SWCNT_EN is defined.
// Optional feature macro: MUX_2TO1_SWCNT_EN adds a saturating source-switch counter.
module mux_2to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] s,
  output logic             s_valid,
  input  logic             s_ready
`ifdef MUX_2TO1_SWCNT_EN
  ,
  output logic [7:0]       sw_count
`endif
);

  logic             w_ld;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_sel_dat;
  logic [WIDTH-1:0] r_s;
  logic             r_s_valid;

  // The output slot can take a new word when it is empty or is being drained this cycle.
  assign w_ld        = !r_s_valid || s_ready;
  assign w_sel_valid = sel ? b_valid : a_valid;
  assign w_sel_dat   = sel ? b : a;

  // The unselected source never sees ready, so it is never consumed.
  assign a_ready = w_ld && !sel;
  assign b_ready = w_ld && sel;

  // Data loads even when the selected source is idle, so s stays deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s       <= '0;
      r_s_valid <= 1'b0;
    end else if (w_ld) begin
      r_s       <= w_sel_dat;
      r_s_valid <= w_sel_valid;
    end
  end

  assign s       = r_s;
  assign s_valid = r_s_valid;

`ifdef MUX_2TO1_SWCNT_EN
  logic       r_have_last;
  logic       r_last_sel;
  logic [7:0] r_sw_count;

  // r_have_last keeps the first valid load after reset from counting as a switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_have_last <= 1'b0;
      r_last_sel  <= 1'b0;
      r_sw_count  <= 8'd0;
    end else if (w_ld && w_sel_valid) begin
      r_have_last <= 1'b1;
      r_last_sel  <= sel;
      if (r_have_last && (sel != r_last_sel) && (r_sw_count != 8'hFF)) begin
        r_sw_count <= r_sw_count + 8'd1;
      end
    end
  end

  assign sw_count = r_sw_count;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: self-checking bench for mux_2to1 (WIDTH=8).
// Vector table for select/backpressure/starvation, hand sequences for reset and streaming,
// randomized traffic against a queue-based occupancy model, and switch-counter checks when enabled.
module tb_mux_2to1;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b;
  logic       b_valid;
  logic       b_ready;
  logic       sel;
  logic [7:0] s;
  logic       s_valid;
  logic       s_ready;
`ifdef MUX_2TO1_SWCNT_EN
  logic [7:0] sw_count;
`endif

  int total;
  int bad;

  // Words accepted from either source but not yet taken by the consumer.
  logic [7:0] q[$];

  typedef struct {
    logic       sel;
    logic       av;
    logic [7:0] a;
    logic       bv;
    logic [7:0] b;
    logic       sr;
    logic       ear;
    logic       ebr;
    logic       esv;
    logic [7:0] es;
  } vec_t;

  vec_t tbl[8];

  mux_2to1 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b        (b),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .sel      (sel),
    .s        (s),
    .s_valid  (s_valid),
    .s_ready  (s_ready)
`ifdef MUX_2TO1_SWCNT_EN
    ,
    .sw_count (sw_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One randomized cycle: readies from the model before the edge, output after it.
  task automatic rnd_cycle();
    bit occupied;
    bit ld;
    occupied = (q.size() > 0);
    ld = !occupied || s_ready;
    #1;
    chk("rnd_a_ready", {31'd0, a_ready}, {31'd0, ld && !sel});
    chk("rnd_b_ready", {31'd0, b_ready}, {31'd0, ld && sel});
    if (occupied && s_ready) void'(q.pop_front());
    if (ld && (sel ? b_valid : a_valid)) q.push_back(sel ? b : a);
    @(posedge clk);
    #1;
    chk("rnd_s_valid", {31'd0, s_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) chk("rnd_s", {24'd0, s}, {24'd0, q[0]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    a = 8'd0; a_valid = 1'b0;
    b = 8'd0; b_valid = 1'b0;
    sel = 1'b0; s_ready = 1'b0;

    //             sel  av  a      bv  b      sr  ear ebr esv es
    tbl[0] = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};
    tbl[1] = '{1'b1, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 8'h05, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 8'h05, 1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07};
    tbl[5] = '{1'b1, 1'b1, 8'h09, 1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b1, 8'h09, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 1'b1, 8'h3c, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3c};

    // Asynchronous reset: outputs clear without any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_s", {24'd0, s}, 32'd0);
    chk("reset_s_valid", {31'd0, s_valid}, 32'd0);
    chk("reset_a_ready", {31'd0, a_ready}, 32'd1);
    chk("reset_b_ready", {31'd0, b_ready}, 32'd0);
`ifdef MUX_2TO1_SWCNT_EN
    chk("reset_sw_count", {24'd0, sw_count}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Select, backpressure with sel toggling, starvation.
    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].sel;
      a_valid = tbl[i].av; a = tbl[i].a;
      b_valid = tbl[i].bv; b = tbl[i].b;
      s_ready = tbl[i].sr;
      #1;
      chk($sformatf("vec%0d_a_ready", i), {31'd0, a_ready}, {31'd0, tbl[i].ear});
      chk($sformatf("vec%0d_b_ready", i), {31'd0, b_ready}, {31'd0, tbl[i].ebr});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_s_valid", i), {31'd0, s_valid}, {31'd0, tbl[i].esv});
      if (tbl[i].esv) chk($sformatf("vec%0d_s", i), {24'd0, s}, {24'd0, tbl[i].es});
    end

    // Reset asserted mid-stall drops the held 0x3c immediately.
    s_ready = 1'b0;
    sel = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    chk("stall_a_ready", {31'd0, a_ready}, 32'd0);
    chk("stall_b_ready", {31'd0, b_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_s", {24'd0, s}, 32'd0);
    chk("midrst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("midrst_b_ready", {31'd0, b_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("post_rst_s_valid", {31'd0, s_valid}, 32'd0);

    // Streaming 0x10..0x1F from A with one-cycle latency.
    sel = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 8'h10 + 8'(i);
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_s_valid", i), {31'd0, s_valid}, 32'd1);
      chk($sformatf("stream%0d_s", i), {24'd0, s}, 32'h10 + 32'(i));
    end
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stream_end_s_valid", {31'd0, s_valid}, 32'd0);

    // Randomized traffic against the occupancy model.
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      a_valid = 1'($urandom);
      b_valid = 1'($urandom);
      sel = ($urandom_range(3) == 0) ? ~sel : sel;
      s_ready = ($urandom_range(3) != 0);
      rnd_cycle();
    end

`ifdef MUX_2TO1_SWCNT_EN
    begin
      int exp_cnt;
      bit have_prev;
      bit prev_sel;
      do_reset();
      exp_cnt = 0;
      have_prev = 1'b0;
      prev_sel = 1'b0;
      a_valid = 1'b1;
      b_valid = 1'b1;
      s_ready = 1'b1;
      sel = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
      end
      chk("swcnt_const", {24'd0, sw_count}, 32'd0);
      do_reset();
      for (int i = 0; i < 300; i++) begin
        sel = 1'(i % 2);
        if (have_prev && (sel != prev_sel) && exp_cnt < 255) exp_cnt++;
        have_prev = 1'b1;
        prev_sel = sel;
        @(posedge clk);
        #1;
      end
      chk("swcnt_sat", {24'd0, sw_count}, 32'(exp_cnt));
      chk("swcnt_sat_255", {24'd0, sw_count}, 32'd255);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_2to1.md
# mux_2to1

Registered, flow-controlled 2:1 selector. It forwards one of two valid/ready input streams (`a`, `b`) to a single output stream `s`, chosen by `sel`. The output holds through one register stage. It sits between two producers and one consumer wherever a datapath must be steered between two sources without dropping or duplicating words.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `a`, `b` and `s`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a`  in  WIDTH  data of input stream A.
- `a_valid`  in  1  A has a word.
- `a_ready`  out  1  A word is consumed this cycle when `a_valid && a_ready`.
- `b`  in  WIDTH  data of input stream B.
- `b_valid`  in  1  B has a word.
- `b_ready`  out  1  B word is consumed this cycle when `b_valid && b_ready`.
- `sel`  in  1  source select: 0 selects A, 1 selects B.
- `s`  out  WIDTH  output data (registered).
- `s_valid`  out  1  `s` holds a word (registered).
- `s_ready`  in  1  consumer accepts `s` this cycle when `s_valid && s_ready`.
- `sw_count`  out  8  switch counter; present only with `MUX_2TO1_SWCNT_EN`.

## Operation
- Load enable `ld = !s_valid || s_ready`, which is combinational.
- `a_ready = ld && !sel`. `b_ready = ld && sel`. The unselected input's ready is always 0, so that input is never consumed.
- On a clock edge with `ld` = 1:
  - `s <= sel ? b : a`.
  - `s_valid <= sel ? b_valid : a_valid`.
- On a clock edge with `ld` = 0: `s` and `s_valid` hold.
- If the selected input is not valid while `ld` = 1, `s_valid` goes to 0. `s` still loads the selected data. Its value is don't-care to consumers, but it must be deterministic.
- A `sel` change while the output is stalled does not alter the held word. The new `sel` takes effect at the next cycle with `ld` = 1.
- Every input word that is consumed appears exactly once on `s`, in order per source.
- `sel` is sampled only at edges where `ld` = 1, and it has no other state effect.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): `s` = 0, `s_valid` = 0, `sw_count` = 0.
- While `rst` is high, `a_ready` and `b_ready` follow `ld`. Since `s_valid` = 0, `ld` = 1, but no edge loads during reset.
- Latency: exactly 1 clock from input handshake to the word on `s`/`s_valid`.
- Throughput: 1 word/cycle when `s_ready` is held 1.
- Ready paths are combinational from `s_ready` and `sel`. No combinational path exists from `a`/`b` data to `s`.
- Reset asserted mid-stall: the held word is discarded and `s_valid` = 0 immediately.

## Configuration
- `MUX_2TO1_SWCNT_EN` defined:
  - An 8-bit `sw_count` port and a 1-bit last-sel register are compiled in.
  - On each output load with a valid word (`ld && selected valid`), if `sel` differs from the `sel` of the previous valid load, `sw_count` increments.
  - `sw_count` saturates at 255.
  - The first valid load after reset never counts.
- Not defined: the `sw_count` port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset: assert `rst` mid-cycle -> `s` = 0 and `s_valid` = 0 immediately, without waiting for a clock edge.
- Basic select, `WIDTH` = 1, valids and `s_ready` tied 1:
  - Drive `a` = 1, `b` = 0, `sel` = 0 -> `s` = 1 after the next edge.
  - Then `sel` = 1 -> `s` = 0 after the following edge.
- Backpressure: `s_ready` = 0 with `s_valid` = 1 -> `a_ready` = `b_ready` = 0 and `s` holds. Toggling `sel` during the stall -> held `s` unchanged. Raise `s_ready` -> the next word comes from the new `sel`.
- Starvation: `sel` = 1 with `b_valid` = 0 and `a_valid` = 1 -> `s_valid` = 0 and A is never consumed (`a_ready` = 0).
- Streaming, `WIDTH` = 8: feed A with 0x10..0x1F on consecutive cycles, `s_ready` = 1 -> `s` reproduces 0x10..0x1F in order, one per cycle, with 1-cycle latency.
- With `MUX_2TO1_SWCNT_EN`:
  - Alternate `sel` on every valid load for 300 cycles -> `sw_count` ends at 255, saturated.
  - Hold `sel` constant -> `sw_count` stays 0.
